// File: rtl/rst_seq_pkg.sv
// rtl/rst_seq_pkg.sv - shared types, legality limits and defaults for the reset release sequencer
package rst_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    HOLD      = 2'd1,
    GAP       = 2'd2,
    RUN       = 2'd3
  } rst_state_e;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_HOLD_CYCLES = 8;
  localparam int DEF_SEQ_GAP     = 4;
  localparam int DEF_CNT_W       = 8;

  function automatic bit cnt_param_ok(input int value, input int cnt_w);
    return (value >= 1) && (value <= (1 << cnt_w) - 1);
  endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// rtl/rst_sync_chain.sv - async-set flop chain that releases its output synchronously
module rst_sync_chain #(
  parameter int STAGES = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic rst_sync_o
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) chain_q <= '1;
    else       chain_q <= chain_q << 1;
  end

  assign rst_sync_o = chain_q[STAGES-1];

endmodule

// File: rtl/reset_release_seq.sv
// rtl/reset_release_seq.sv - async-assert, sequenced sync-release of core and peripheral resets
module reset_release_seq
  import rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int SEQ_GAP     = DEF_SEQ_GAP,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic CLK,
  input  logic IN_RST,
  input  logic SW_RST_REQ,
  output logic OUT_RST_CORE,
  output logic OUT_RST_PERIPH,
  output logic RST_DONE,
  output logic BUSY
);

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
    $error("reset_release_seq: SYNC_STAGES out of range");
  end
  if (!cnt_param_ok(HOLD_CYCLES, CNT_W)) begin : g_bad_hold
    $error("reset_release_seq: HOLD_CYCLES out of range");
  end
  if (!cnt_param_ok(SEQ_GAP, CNT_W)) begin : g_bad_gap
    $error("reset_release_seq: SEQ_GAP out of range");
  end

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(SEQ_GAP - 1);

  rst_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             core_q, core_d;
  logic             periph_q, periph_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             sync_rst;

  // The WAIT_SYNC->HOLD transition is the final synchronizer stage, so HOLD
  // is entered exactly at edge SYNC_STAGES.
  rst_sync_chain #(
    .STAGES (SYNC_STAGES - 1)
  ) u_sync (
    .clk_i      (CLK),
    .rst_i      (IN_RST),
    .rst_sync_o (sync_rst)
  );

  always_ff @(posedge CLK or posedge IN_RST) begin
    if (IN_RST) begin
      state_q  <= WAIT_SYNC;
      cnt_q    <= '0;
      core_q   <= 1'b1;
      periph_q <= 1'b1;
      done_q   <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      core_q   <= core_d;
      periph_q <= periph_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      WAIT_SYNC: if (!sync_rst) state_d = HOLD;
      HOLD: begin
        if (cnt_q == HOLD_LAST) state_d = GAP;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      GAP: begin
        if (cnt_q == GAP_LAST) state_d = RUN;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      RUN: if (SW_RST_REQ) state_d = HOLD;
      default: state_d = WAIT_SYNC;
    endcase
  end

  // Output flops load the value implied by the upcoming state.
  always_comb begin
    core_d   = (state_d == WAIT_SYNC) || (state_d == HOLD);
    periph_d = (state_d != RUN);
    busy_d   = (state_d != RUN);
    done_d   = (state_q == GAP) && (state_d == RUN);
  end

  assign OUT_RST_CORE   = core_q;
  assign OUT_RST_PERIPH = periph_q;
  assign RST_DONE       = done_q;
  assign BUSY           = busy_q;

endmodule
